// File: rtl/frag_port_arbiter_pkg.sv
// Shared types and default sizes for the fragment read-port arbiter.
package frag_port_arbiter_pkg;

   localparam int unsigned IndexLengthDef      = 16;
   localparam int unsigned Log2FragmentSizeDef = 8;
   localparam int unsigned FRAGMENT_SIZE       = 2 ** Log2FragmentSizeDef;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StRelease
   } arb_state_e;

   typedef logic [IndexLengthDef-1:0] index_t;

endpackage

// File: rtl/frag_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, modulo NUM_REQ.
module frag_port_arbiter_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IdxW    = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IdxW-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_valid
);

   logic [NUM_REQ-1:0] rot_req;
   logic [NUM_REQ-1:0] rot_gnt;
   logic               found;

   // Rotate so the pointer position lands at bit 0, fixed-priority pick, rotate back.
   always_comb begin
      rot_req = NUM_REQ'({i_req, i_req} >> i_ptr);
      rot_gnt = '0;
      found   = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!found && rot_req[i]) begin
            rot_gnt[i] = 1'b1;
            found      = 1'b1;
         end
      end
      o_gnt   = NUM_REQ'(({rot_gnt, rot_gnt} << i_ptr) >> NUM_REQ);
      o_valid = |i_req;
   end

endmodule

// File: rtl/frag_port_arbiter.sv
// Round-robin arbiter sharing the double-buffer fragment read port between NUM_REQ fetchers,
// with per-access watchdog and aggregated job-done signalling.
module frag_port_arbiter
   import frag_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ            = 2,
   parameter int unsigned INDEX_LENGTH       = IndexLengthDef,
   parameter int unsigned LOG2_FRAGMENT_SIZE = Log2FragmentSizeDef,
   parameter int unsigned BYTE               = 8,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic                                        clk,
   input  logic                                        rstn,
   input  logic [NUM_REQ-1:0]                          i_req,
   input  logic [NUM_REQ*INDEX_LENGTH-1:0]             i_addr,
   input  logic [NUM_REQ-1:0]                          i_done,
   output logic [NUM_REQ-1:0]                          o_frag_ready,
   output logic [(2**LOG2_FRAGMENT_SIZE)*BYTE-1:0]     o_frag,
   output logic [NUM_REQ-1:0]                          o_timeout,
   output logic [INDEX_LENGTH-1:0]                     o_db_addr,
   output logic                                        o_db_req,
   output logic                                        o_db_done,
   input  logic [(2**LOG2_FRAGMENT_SIZE)*BYTE-1:0]     i_db_frag,
   input  logic                                        i_db_frag_ready,
   output logic                                        o_busy
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned WdW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   arb_state_e               state_q, state_d;
   logic [IdxW-1:0]          grant_q, grant_d;
   logic [IdxW-1:0]          rr_q, rr_d;
   logic [INDEX_LENGTH-1:0]  addr_q, addr_d;
   logic [WdW-1:0]           wd_q, wd_d;
   logic [NUM_REQ-1:0]       timeout_q, timeout_d;
   logic [NUM_REQ-1:0]       mask_q, mask_d;
   logic                     done_q, done_d;

   logic [NUM_REQ-1:0]       pick_gnt;
   logic                     pick_valid;
   logic [IdxW-1:0]          pick_idx;
   logic [INDEX_LENGTH-1:0]  pick_addr;
   logic [NUM_REQ-1:0]       mask_set;
   logic [NUM_REQ-1:0]       frag_ready;
   logic                     db_req;

   frag_port_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_rr_pick (
      .i_req   (i_req),
      .i_ptr   (rr_q),
      .o_gnt   (pick_gnt),
      .o_valid (pick_valid)
   );

   always_comb begin
      pick_idx  = '0;
      pick_addr = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (pick_gnt[k]) begin
            pick_idx  = IdxW'(k);
            pick_addr = i_addr[k*INDEX_LENGTH +: INDEX_LENGTH];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      addr_d     = addr_q;
      wd_d       = wd_q;
      timeout_d  = timeout_q;
      mask_set   = '0;
      frag_ready = '0;
      db_req     = 1'b0;
      unique case (state_q)
         StIdle: begin
            wd_d = '0;
            if (pick_valid) begin
               grant_d  = pick_idx;
               addr_d   = pick_addr;
               mask_set = pick_gnt;
               state_d  = StGrant;
            end
         end
         StGrant: begin
            db_req = 1'b1;
            // A response in the final watchdog cycle still wins over the abort.
            if (i_db_frag_ready) begin
               frag_ready[grant_q] = 1'b1;
               state_d             = StRelease;
            end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
               timeout_d[grant_q] = 1'b1;
               state_d            = StRelease;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         StRelease: begin
            wd_d    = '0;
            rr_d    = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // A grant setting bit k wins over a simultaneous done clearing it.
   always_comb begin
      mask_d = (mask_q & ~i_done) | mask_set;
      done_d = (|mask_q) & ~(|mask_d);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         rr_q      <= '0;
         addr_q    <= '0;
         wd_q      <= '0;
         timeout_q <= '0;
         mask_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         addr_q    <= addr_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
         mask_q    <= mask_d;
         done_q    <= done_d;
      end
   end

   assign o_frag_ready = frag_ready;
   assign o_frag       = (|frag_ready) ? i_db_frag : '0;
   assign o_timeout    = timeout_q;
   assign o_db_addr    = addr_q;
   assign o_db_req     = db_req;
   assign o_db_done    = done_q;
   assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_frag_port_arbiter.sv
// Directed self-checking bench for frag_port_arbiter (2 requesters, 32-bit fragments, 8-cycle watchdog).
module tb_frag_port_arbiter;

   localparam int unsigned NReq  = 2;
   localparam int unsigned IdxL  = 16;
   localparam int unsigned FragW = 32;

   logic              clk;
   logic              rstn;
   logic [NReq-1:0]   i_req;
   logic [NReq*IdxL-1:0] i_addr;
   logic [NReq-1:0]   i_done;
   logic [NReq-1:0]   o_frag_ready;
   logic [FragW-1:0]  o_frag;
   logic [NReq-1:0]   o_timeout;
   logic [IdxL-1:0]   o_db_addr;
   logic              o_db_req;
   logic              o_db_done;
   logic [FragW-1:0]  i_db_frag;
   logic              i_db_frag_ready;
   logic              o_busy;

   int errors = 0;
   int checks = 0;

   frag_port_arbiter #(
      .NUM_REQ            (NReq),
      .INDEX_LENGTH       (IdxL),
      .LOG2_FRAGMENT_SIZE (2),
      .BYTE               (8),
      .TIMEOUT_CYCLES     (8)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .i_req           (i_req),
      .i_addr          (i_addr),
      .i_done          (i_done),
      .o_frag_ready    (o_frag_ready),
      .o_frag          (o_frag),
      .o_timeout       (o_timeout),
      .o_db_addr       (o_db_addr),
      .o_db_req        (o_db_req),
      .o_db_done       (o_db_done),
      .i_db_frag       (i_db_frag),
      .i_db_frag_ready (i_db_frag_ready),
      .o_busy          (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if ({o_frag_ready, o_frag, o_timeout, o_db_addr, o_db_req, o_db_done, o_busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b frag=%h to=%b addr=%h req=%b done=%b busy=%b, want all 0",
                  o_frag_ready, o_frag, o_timeout, o_db_addr, o_db_req, o_db_done, o_busy);
      end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b want 0", o_busy);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      i_addr[0 +: IdxL] = 16'h0005;
      i_req = 2'b01;
      #1;
      checks++;
      if (o_db_req !== 1'b0) begin
         errors++;
         $display("FAIL single_req_latency0: got req=%b want 0", o_db_req);
      end
      @(negedge clk);
      #1;
      checks++;
      if (o_db_req !== 1'b1 || o_db_addr !== 16'h0005 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: got req=%b addr=%h busy=%b want 1 0005 1", o_db_req, o_db_addr, o_busy);
      end
      repeat (2) begin
         @(negedge clk);
         #1;
         checks++;
         if (o_frag_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_no_early_ready: got %b want 00", o_frag_ready);
         end
      end
      @(negedge clk);
      i_db_frag_ready = 1'b1;
      i_db_frag = 32'hA5A5_0001;
      i_req = 2'b00;
      #1;
      checks++;
      if (o_frag_ready !== 2'b01 || o_frag !== 32'hA5A5_0001 || o_db_req !== 1'b1) begin
         errors++;
         $display("FAIL single_response: got ready=%b frag=%h req=%b want 01 a5a50001 1",
                  o_frag_ready, o_frag, o_db_req);
      end
      @(negedge clk);
      i_db_frag_ready = 1'b0;
      #1;
      checks++;
      if (o_db_req !== 1'b0 || o_frag_ready !== 2'b00) begin
         errors++;
         $display("FAIL single_release: got req=%b ready=%b want 0 00", o_db_req, o_frag_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_back_idle: got busy=%b want 0", o_busy);
      end
   endtask

   task automatic test_contention();
      logic [IdxL-1:0] exp_addr;
      logic [NReq-1:0] exp_rdy;
      do_reset();
      @(negedge clk);
      i_addr = {16'h0020, 16'h0010};
      i_req = 2'b11;
      for (int a = 0; a < 4; a++) begin
         exp_addr = (a % 2 == 0) ? 16'h0010 : 16'h0020;
         exp_rdy  = (a % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         #1;
         checks++;
         if (o_db_req !== 1'b1 || o_db_addr !== exp_addr) begin
            errors++;
            $display("FAIL contention_addr[%0d]: got req=%b addr=%h want 1 %h", a, o_db_req, o_db_addr, exp_addr);
         end
         @(negedge clk);
         @(negedge clk);
         i_db_frag_ready = 1'b1;
         i_db_frag = 32'h1000_0000 + a;
         #1;
         checks++;
         if (o_frag_ready !== exp_rdy || o_frag !== 32'h1000_0000 + a) begin
            errors++;
            $display("FAIL contention_ready[%0d]: got ready=%b frag=%h want %b %h",
                     a, o_frag_ready, o_frag, exp_rdy, 32'h1000_0000 + a);
         end
         @(negedge clk);
         i_db_frag_ready = 1'b0;
         if (a == 3) i_req = 2'b00;
         #1;
         checks++;
         if (o_db_req !== 1'b0) begin
            errors++;
            $display("FAIL contention_gap[%0d]: got req=%b want 0", a, o_db_req);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_stray();
      @(negedge clk);
      i_db_frag_ready = 1'b1;
      i_db_frag = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (o_frag_ready !== 2'b00 || o_frag !== 32'h0) begin
         errors++;
         $display("FAIL stray_ready: got ready=%b frag=%h want 00 0", o_frag_ready, o_frag);
      end
      @(negedge clk);
      i_db_frag_ready = 1'b0;
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_db_req !== 1'b0) begin
         errors++;
         $display("FAIL stray_state: got busy=%b req=%b want 0 0", o_busy, o_db_req);
      end
   endtask

   task automatic test_timeout();
      int hi;
      bit saw_rdy;
      hi = 0;
      saw_rdy = 1'b0;
      @(negedge clk);
      i_addr[IdxL +: IdxL] = 16'h0033;
      i_req = 2'b10;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         i_req = 2'b00;
         #1;
         if (o_frag_ready !== 2'b00) saw_rdy = 1'b1;
         if (o_db_req === 1'b1) hi++;
         else break;
      end
      checks++;
      if (hi != 8) begin
         errors++;
         $display("FAIL timeout_req_cycles: got %0d want 8", hi);
      end
      checks++;
      if (saw_rdy) begin
         errors++;
         $display("FAIL timeout_no_ready: got a ready pulse, want none");
      end
      checks++;
      if (o_timeout !== 2'b10) begin
         errors++;
         $display("FAIL timeout_flag: got %b want 10", o_timeout);
      end
      @(negedge clk);
      i_addr[0 +: IdxL] = 16'h0044;
      i_req = 2'b01;
      @(negedge clk);
      i_req = 2'b00;
      #1;
      checks++;
      if (o_db_req !== 1'b1 || o_db_addr !== 16'h0044) begin
         errors++;
         $display("FAIL timeout_next_grant: got req=%b addr=%h want 1 0044", o_db_req, o_db_addr);
      end
      @(negedge clk);
      i_db_frag_ready = 1'b1;
      i_db_frag = 32'h0000_0044;
      #1;
      checks++;
      if (o_frag_ready !== 2'b01 || o_timeout !== 2'b10) begin
         errors++;
         $display("FAIL timeout_next_serve: got ready=%b to=%b want 01 10", o_frag_ready, o_timeout);
      end
      @(negedge clk);
      i_db_frag_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_grant();
      @(negedge clk);
      i_addr[IdxL +: IdxL] = 16'h0077;
      i_req = 2'b10;
      @(negedge clk);
      i_req = 2'b00;
      #1;
      checks++;
      if (o_db_req !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_granted: got req=%b want 1", o_db_req);
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if (o_db_req !== 1'b0 || o_busy !== 1'b0 || o_timeout !== 2'b00) begin
         errors++;
         $display("FAIL rstmid_cleared: got req=%b busy=%b to=%b want 0 0 00", o_db_req, o_busy, o_timeout);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      i_db_frag_ready = 1'b1;
      #1;
      checks++;
      if (o_frag_ready !== 2'b00) begin
         errors++;
         $display("FAIL rstmid_late_resp: got ready=%b want 00", o_frag_ready);
      end
      @(negedge clk);
      i_db_frag_ready = 1'b0;
   endtask

   task automatic serve(input int k);
      bit got;
      got = 1'b0;
      @(negedge clk);
      i_req[k] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (o_db_req === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      i_req = '0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL serve_grant[%0d]: got no o_db_req within 10 cycles, want grant", k);
      end
      @(negedge clk);
      i_db_frag_ready = 1'b1;
      @(negedge clk);
      i_db_frag_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_done();
      do_reset();
      serve(0);
      serve(1);
      @(negedge clk);
      i_done = 2'b01;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (o_db_done !== 1'b0) begin
            errors++;
            $display("FAIL done_partial[%0d]: got %b want 0", c, o_db_done);
         end
         @(negedge clk);
         i_done = 2'b00;
      end
      i_done = 2'b10;
      #1;
      checks++;
      if (o_db_done !== 1'b0) begin
         errors++;
         $display("FAIL done_same_cycle: got %b want 0", o_db_done);
      end
      @(negedge clk);
      i_done = 2'b00;
      #1;
      checks++;
      if (o_db_done !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse: got %b want 1", o_db_done);
      end
      @(negedge clk);
      #1;
      checks++;
      if (o_db_done !== 1'b0) begin
         errors++;
         $display("FAIL done_one_cycle: got %b want 0", o_db_done);
      end
      @(negedge clk);
      i_done = 2'b10;
      @(negedge clk);
      i_done = 2'b00;
      #1;
      checks++;
      if (o_db_done !== 1'b0) begin
         errors++;
         $display("FAIL done_repeat: got %b want 0", o_db_done);
      end
   endtask

   initial begin
      rstn = 1'b0;
      i_req = '0;
      i_addr = '0;
      i_done = '0;
      i_db_frag = '0;
      i_db_frag_ready = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_stray();
      test_timeout();
      test_reset_mid_grant();
      test_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frag_port_arbiter.md
Name: frag_port_arbiter

Overview:
- Round-robin arbiter that shares the single fragment read port of the double buffer between NUM_REQ fragment fetchers. This lets several fetchers drain sorter index sets in parallel.
- Sits between the fetchers and the double buffer read side. It serialises address requests, routes each returned fragment to its owner, aggregates done, and guards each access with a watchdog.

Parameters:
- NUM_REQ, 2, number of requesting fetchers (2..8).
- INDEX_LENGTH, 16, fragment index width in bits.
- LOG2_FRAGMENT_SIZE, 8, fragment is 2**LOG2_FRAGMENT_SIZE bytes.
- BYTE, 8, bits per byte.
- TIMEOUT_CYCLES, 1024, maximum wait for a fragment response before abort.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-fetcher request level. Held with its address until the matching o_frag_ready.
- i_addr  in  NUM_REQ*INDEX_LENGTH  per-fetcher fragment index. Requester k uses slice k.
- i_done  in  NUM_REQ  per-fetcher one-cycle pulse: job finished.
- o_frag_ready  out  NUM_REQ  one-hot pulse: fragment valid for that requester.
- o_frag  out  FRAGMENT_SIZE*BYTE  fragment data, shared by all requesters.
- o_timeout  out  NUM_REQ  sticky per-requester error flag.
- o_db_addr  out  INDEX_LENGTH  address to double buffer.
- o_db_req  out  1  read request to double buffer.
- o_db_done  out  1  pulse to double buffer: all active jobs finished.
- i_db_frag  in  FRAGMENT_SIZE*BYTE  fragment from double buffer.
- i_db_frag_ready  in  1  fragment valid from double buffer.
- o_busy  out  1  high while not in IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, grant 0, active mask 0, watchdog 0, o_timeout 0.
- Reset asserted mid-access drops everything immediately. No pulse is emitted.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any i_req bit is set, pick the first set bit at or after the rr pointer, searching modulo NUM_REQ.
  - Latch the grant index and its address into o_db_addr. Go to GRANT next cycle; o_db_req rises then.
  - Latency is 1 cycle from request sample to o_db_req.
- GRANT:
  - o_db_req=1 and o_db_addr is stable. The watchdog increments each cycle.
  - On i_db_frag_ready: o_frag_ready[grant]=1 combinationally in the same cycle, o_db_req stays 1 that cycle, then go to RELEASE.
  - o_frag is i_db_frag passed through unregistered. It is valid only while some o_frag_ready bit is 1.
- Watchdog: if the counter reaches TIMEOUT_CYCLES-1 without i_db_frag_ready:
  - Set o_timeout[grant]=1 (sticky until reset). Deassert o_db_req and go to RELEASE.
  - No o_frag_ready pulse is issued.
- RELEASE (1 cycle):
  - o_db_req=0, watchdog cleared, rr pointer = grant+1 mod NUM_REQ. Go to IDLE.
  - Guaranteed gap: o_db_req is low for at least 1 cycle between accesses.
- i_db_frag_ready seen outside GRANT is ignored. No o_frag_ready is pulsed.
- A requester that drops i_req while granted does not cancel the access. The response is still delivered to that index.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1. The worst-case wait is NUM_REQ-1 accesses.
- Active mask:
  - Bit k is set on the first grant to k. Bit k is cleared on i_done[k].
  - If a grant and i_done hit the same k in the same cycle, the set wins.
- o_db_done: one-cycle pulse in the cycle after the mask goes nonzero to zero. No pulse if the mask was already zero.
- A done from a requester whose mask bit is 0 is ignored.

Decomposition:
- Shared package holds:
  - fragment width localparam, FRAGMENT_SIZE = 2**LOG2_FRAGMENT_SIZE;
  - the state enum (IDLE, GRANT, RELEASE);
  - the index type of width INDEX_LENGTH.
- One sub-module: rr_pick, a combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: one-hot grant and valid.
- The FSM, watchdog, address mux and done mask stay in the top.

Test Plan:
- Single request: i_req=01, addr0=0x0005; DB replies 3 cycles after o_db_req -> o_db_req rises 1 cycle after i_req with o_db_addr=0x0005; o_frag_ready=01 coincides with i_db_frag_ready; o_db_req is low the next cycle.
- Contention: i_req=11 held, addr0=0x0010, addr1=0x0020, DB replies in 2 cycles -> grant order 0,1,0,1; o_db_addr alternates 0x0010/0x0020; exactly one o_frag_ready bit per access.
- Timeout: TIMEOUT_CYCLES=8, requester 1 requests, DB silent -> o_db_req high exactly 8 cycles; o_timeout=10 sticky; no o_frag_ready; next request is served normally.
- Done aggregation: grant both requesters, i_done[0] then 4 cycles later i_done[1] -> o_db_done pulses once, 1 cycle after i_done[1]; a second i_done[1] produces no pulse.
- Stray response: i_db_frag_ready asserted in IDLE -> o_frag_ready stays 00 and the state is unchanged.
- Reset mid-GRANT: rstn low for 1 cycle while waiting -> o_db_req=0, o_busy=0, o_timeout=0 immediately; a later DB response produces no o_frag_ready.
